// File: rtl/issue_queue.sv
// issue_queue: in-order dual-push/dual-pop instruction queue with hazard-checked head pairing
module issue_queue #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              stall,
    input  logic [1:0]        in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [16:0]       in_meta0,
    input  logic [16:0]       in_meta1,
    output logic [1:0]        out_valid,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [16:0]       out_meta0,
    output logic [16:0]       out_meta1
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [16:0]       mem_meta [DEPTH];
    logic [AW-1:0]     head, tail, head1;
    logic [CW-1:0]     count, npush, npop;
    logic [AW-1:0]     npush_a, npop_a;
    logic [16:0]       hm, h1m;
    logic              push0, push1, pop0, pop1, raw, pair_ok, live;

    assign head1    = head + AW'(1);
    assign hm       = mem_meta[head];
    assign h1m      = mem_meta[head1];
    assign live     = rstn & ~flush;
    assign in_ready = live & (count <= CW'(DEPTH - 2));
    // in_valid=10 is not a legal code and must push nothing
    assign push0    = in_ready & in_valid[0];
    assign push1    = push0 & in_valid[1];
    // r0 writes never create a RAW hazard
    assign raw      = hm[15] & (|hm[14:10]) & ((h1m[4:0] == hm[14:10]) | (h1m[9:5] == hm[14:10]));
    assign pair_ok  = ~hm[16] & ~h1m[16] & ~raw;
    assign out_valid[0] = live & (count >= CW'(1));
    assign out_valid[1] = live & (count >= CW'(2)) & pair_ok;
    assign pop0     = out_valid[0] & ~stall;
    assign pop1     = out_valid[1] & ~stall;
    assign npush    = CW'(push0) + CW'(push1);
    assign npop     = CW'(pop0) + CW'(pop1);
    assign npush_a  = AW'(push0) + AW'(push1);
    assign npop_a   = AW'(pop0) + AW'(pop1);
    assign out_data0 = rstn ? mem_data[head]  : '0;
    assign out_data1 = rstn ? mem_data[head1] : '0;
    assign out_meta0 = rstn ? hm  : '0;
    assign out_meta1 = rstn ? h1m : '0;

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + npop_a;
            tail  <= tail + npush_a;
            count <= count + npush - npop;
        end
    end

    always_ff @(posedge clk) begin
        if (push0) begin
            mem_data[tail] <= in_data0;
            mem_meta[tail] <= in_meta0;
        end
        if (push1) begin
            mem_data[tail + AW'(1)] <= in_data1;
            mem_meta[tail + AW'(1)] <= in_meta1;
        end
    end

    count_range: assert property (@(posedge clk) disable iff (!rstn) count <= CW'(DEPTH));
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed checks of push/pop, pairing hazards, full, stall, flush and reset
module tb_issue_queue;
    logic         clk = 0;
    logic         rstn, flush, stall, in_ready;
    logic [1:0]   in_valid, out_valid;
    logic [127:0] in_data0, in_data1, out_data0, out_data1;
    logic [16:0]  in_meta0, in_meta1, out_meta0, out_meta1;
    int errors = 0;
    int checks = 0;

    issue_queue #(.DEPTH(8), .DATA_W(128)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data0(in_data0), .in_data1(in_data1),
        .in_meta0(in_meta0), .in_meta1(in_meta1),
        .out_valid(out_valid), .out_data0(out_data0), .out_data1(out_data1),
        .out_meta0(out_meta0), .out_meta1(out_meta1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] mt(input logic solo, input logic we,
                                       input logic [4:0] rd, input logic [4:0] rs2, input logic [4:0] rs1);
        return {solo, we, rd, rs2, rs1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] v, input logic [127:0] d0, input logic [16:0] m0,
                        input logic [127:0] d1, input logic [16:0] m1);
        in_valid = v; in_data0 = d0; in_meta0 = m0; in_data1 = d1; in_meta1 = m1;
        step();
        in_valid = 2'b00;
    endtask

    initial begin
        rstn = 0; flush = 0; stall = 0; in_valid = 0;
        in_data0 = 0; in_data1 = 0; in_meta0 = 0; in_meta1 = 0;
        step(); step();
        check("rst_valid", out_valid, 2'b00);
        check("rst_ready", in_ready, 1'b0);
        check("rst_data0", out_data0, 0);
        rstn = 1; #1;
        check("post_rst_ready", in_ready, 1'b1);
        check("post_rst_count", dut.count, 0);
        check("post_rst_valid", out_valid, 2'b00);

        push(2'b11, 128'h11, mt(0, 1, 1, 3, 2), 128'h22, mt(0, 1, 4, 6, 5));
        check("pair_valid", out_valid, 2'b11);
        check("pair_count", dut.count, 2);
        check("pair_data0", out_data0, 128'h11);
        check("pair_data1", out_data1, 128'h22);
        check("pair_meta1", out_meta1, mt(0, 1, 4, 6, 5));
        step();
        check("pair_drain", dut.count, 0);
        check("pair_drain_v", out_valid, 2'b00);

        push(2'b11, 128'h33, mt(0, 1, 5, 0, 0), 128'h44, mt(0, 0, 0, 5, 7));
        check("raw_v1", out_valid, 2'b01);
        check("raw_d1", out_data0, 128'h33);
        step();
        check("raw_v2", out_valid, 2'b01);
        check("raw_d2", out_data0, 128'h44);
        check("raw_cnt", dut.count, 1);
        step();
        check("raw_drain", dut.count, 0);

        push(2'b11, 128'h55, mt(0, 1, 0, 0, 0), 128'h66, mt(0, 0, 0, 9, 0));
        check("r0_valid", out_valid, 2'b11);
        step();
        push(2'b11, 128'h77, mt(1, 0, 0, 0, 0), 128'h88, mt(0, 0, 0, 0, 0));
        check("solo_valid", out_valid, 2'b01);
        step();
        check("solo_cnt", dut.count, 1);
        step();
        check("solo_drain", dut.count, 0);

        stall = 1;
        for (int i = 0; i < 3; i++)
            push(2'b11, 128'hF000 + 128'(2 * i), 17'h0, 128'hF000 + 128'(2 * i + 1), 17'h0);
        check("fill6_cnt", dut.count, 6);
        check("fill6_ready", in_ready, 1'b1);
        push(2'b11, 128'hF006, 17'h0, 128'hF007, 17'h0);
        check("full_cnt", dut.count, 8);
        check("full_ready", in_ready, 1'b0);
        check("full_valid_stall", out_valid, 2'b11);
        check("full_data0", out_data0, 128'hF000);
        stall = 0;
        step();
        check("popfull_cnt", dut.count, 6);
        check("popfull_ready", in_ready, 1'b1);
        check("popfull_data0", out_data0, 128'hF002);
        check("popfull_data1", out_data1, 128'hF003);
        step();
        check("cnt4", dut.count, 4);

        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_cnt", dut.count, 4);
            check("stall_data0", out_data0, 128'hF004);
            check("stall_valid", out_valid, 2'b11);
        end
        push(2'b11, 128'hA0, 17'h0, 128'hA1, 17'h0);
        check("stall_push_cnt", dut.count, 6);
        stall = 0;
        step();
        check("cnt4b", dut.count, 4);
        stall = 1;
        push(2'b01, 128'hE0, 17'h0, 128'hE1, 17'h0);
        check("cnt5", dut.count, 5);

        flush = 1; in_valid = 2'b11; in_data0 = 128'hBAD0; in_data1 = 128'hBAD1; #1;
        check("flush_ready", in_ready, 1'b0);
        check("flush_valid", out_valid, 2'b00);
        step();
        flush = 0; in_valid = 2'b00; stall = 0; #1;
        check("flush_cnt", dut.count, 0);
        check("flush_valid2", out_valid, 2'b00);
        check("flush_ready2", in_ready, 1'b1);
        check("flush_nodata0", out_data0, 128'hA0);
        check("flush_nodata1", out_data1, 128'hA1);

        push(2'b10, 128'hC0, 17'h0, 128'hC1, 17'h0);
        check("v10_cnt", dut.count, 0);

        stall = 1;
        push(2'b11, 128'hD0, 17'h0, 128'hD1, 17'h0);
        rstn = 0;
        step();
        rstn = 1; stall = 0; #1;
        check("midrst_cnt", dut.count, 0);
        check("midrst_valid", out_valid, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
